rv_regs_ctrl: RTL
=================

# rv_regs_ctrl

Sequencing and arbitration controller placed between the core pipeline, the debug module, and the `rv_regs` register file. After reset it clears x1..x31 to zero, because the register-file storage has no reset. It then passes core read and write traffic through to the register file. It also time-shares the file's single write port and its rs1 read port with a debug requester, using a req/ack handshake and a starvation guard.

## Interface
Parameters:
- `CLEAR_ON_RESET`, default 1: 1 means run the clear sequence after reset; 0 means go straight to IDLE.
- `STARVE_LIM`, default 4: number of consecutive cycles a debug write may be blocked by core writes before debug wins.

Ports:
- `i_clk` in 1: the single clock.
- `i_reset` in 1: reset, synchronous, active-high.
- `i_core_rs1`, `i_core_rs2` in 5: core read addresses.
- `i_core_rd` in 5, `i_core_write` in 1, `i_core_data` in 32: core write port.
- `o_core_stall` out 1: the core's request this cycle was not serviced; the core holds its inputs.
- `i_dbg_req`, `i_dbg_we` in 1; `i_dbg_addr` in 5; `i_dbg_wdata` in 32: debug request.
- `o_dbg_ack` out 1: one-cycle completion pulse.
- `o_dbg_rdata` out 32: debug read result, valid while `o_dbg_ack` is high.
- `o_rf_rs1`, `o_rf_rs2`, `o_rf_rd` out 5; `o_rf_write` out 1; `o_rf_data` out 32: drive the register file (combinational).
- `i_rf_data1` in 32: register-file rs1 read data, registered, one-cycle latency, x0 reads 0.
- `o_ready` out 1: the clear sequence is complete.

## Operation
The FSM states are CLEAR, IDLE, DBG_RD and DBG_WR.

- **Reset:** if `CLEAR_ON_RESET` is 1 the FSM enters CLEAR; otherwise it enters IDLE. Reset also sets:
  - clear counter = 1, starvation counter = 0;
  - `o_dbg_ack` = 0, `o_dbg_rdata` = 0;
  - `o_ready` = (`CLEAR_ON_RESET` == 0).
- **CLEAR:**
  - Drive `o_rf_write`=1, `o_rf_rd`=cnt, `o_rf_data`=0, and increment cnt.
  - When cnt == 31 has been written, go to IDLE and set `o_ready`=1.
  - `o_core_stall`=1 throughout. Debug requests are not accepted.
- **IDLE:** pass core addresses and writes through to the register file. Core or debug writes with rd = 0 are dropped (`o_rf_write`=0).
- **Debug read accepted in IDLE:** `i_dbg_req`=1 and `i_dbg_we`=0.
  - In the same cycle, drive `o_rf_rs1`=`i_dbg_addr` and `o_core_stall`=1. The core's rs1 lookup is lost and the core repeats it.
  - Go to DBG_RD.
- **DBG_RD:**
  - Capture `i_rf_data1` into `o_dbg_rdata` and pulse `o_dbg_ack`=1.
  - The core passes through. Return to IDLE.
- **Debug write accepted in IDLE:** `i_dbg_req`=1, `i_dbg_we`=1, and either `i_core_write`=0 or the starvation counter has reached `STARVE_LIM`.
  - Drive `o_rf_rd`=`i_dbg_addr`, `o_rf_data`=`i_dbg_wdata`, `o_rf_write`=(addr≠0).
  - If `i_core_write`=1 in that cycle, `o_core_stall`=1 and the core write is not performed.
  - Go to DBG_WR.
- **Blocked debug write:** if a debug write is pending but a core write wins, increment the starvation counter (saturating). The counter clears whenever a debug write is accepted.
- **DBG_WR:** pulse `o_dbg_ack`=1, pass the core through, return to IDLE.
- **Handshake rules:**
  - The requester holds `req`, `we`, `addr` and `wdata` stable until ack, and drops `req` in the ack cycle.
  - No new request is accepted in an ack cycle.
  - `o_dbg_rdata` holds its value after ack until the next debug read.
- **Debug read of x0:** returns 0, because the register file gates it.
- **Reset mid-operation:** any state goes to CLEAR (or IDLE); a pending ack is cancelled.

## Timing
- Clear sequence: 31 cycles of writes (x1..x31). `o_ready` rises in the first IDLE cycle.
- Core reads: the controller adds no latency; the register file's one-cycle read latency is unchanged.
- Debug read: request accepted in cycle N; ack and data in cycle N+1; earliest next acceptance in cycle N+2.
- Debug write: written in the accept cycle N; ack in cycle N+1.
- Starvation: with core writes every cycle, a debug write is accepted on the (`STARVE_LIM`+1)th cycle of `req`.
- `o_core_stall` is combinational from state and the inputs. It is 1 only in CLEAR, in a debug-read accept cycle, and in a debug-write-preempts-core cycle.

## Structure
- Package `rv_regs_ctrl_pkg` holds:
  - the state enum `regs_ctrl_state_t` (CLEAR, IDLE, DBG_RD, DBG_WR);
  - `REG_ZERO` = 5'd0 and `REG_LAST` = 5'd31.
- Single module with no sub-modules; the clear counter and starvation counter are inline.
- `rv_regs` is instantiated alongside this block at the next level up, not inside it.

## Test plan
- **Reset clear:** `i_reset` held 2 cycles, then released.
  - Required: 31 writes of 0 to rd=1..31, `o_core_stall`=1 throughout, then `o_ready`=1.
  - Reading any register afterwards returns 0.
- **Debug write/read:**
  - Debug write 0xDEADBEEF to x5: ack follows one cycle later.
  - Debug read of x5: ack with `o_dbg_rdata`=0xDEADBEEF, with `o_core_stall`=1 only in the read-accept cycle.
- **Starvation:** core writes x3 every cycle while a debug write of 0x12345678 to x7 is pending.
  - Required: debug accepted on cycle 5 (`STARVE_LIM`=4) with `o_core_stall`=1 in that cycle.
  - x7 reads 0x12345678.
- **x0 protection:** debug write 0xFFFFFFFF to x0, and a core write to x0.
  - Required: `o_rf_write`=0 for both; a debug read of x0 returns 0 with ack.
- **Reset mid-operation:** `i_reset` asserted in the DBG_RD cycle.
  - Required: no ack, `o_dbg_rdata`=0, the clear sequence restarts at x1.
- **CLEAR_ON_RESET=0:** after reset, `o_ready`=1 immediately and there is no write activity.

Source files
------------

// File: rtl/rv_regs_ctrl_pkg.sv
// Shared types and constants for the register-file sequencing controller.
package rv_regs_ctrl_pkg;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        IDLE   = 2'd1,
        DBG_RD = 2'd2,
        DBG_WR = 2'd3
    } regs_ctrl_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_LAST = 5'd31;

endpackage

// File: rtl/rv_regs_ctrl.sv
// Sequencing and arbitration controller in front of the rv_regs register file.
// Clears x1..x31 after reset, then passes core traffic through while sharing
// the write port and the rs1 read port with a debug requester.
module rv_regs_ctrl
    import rv_regs_ctrl_pkg::*;
#(
    parameter int CLEAR_ON_RESET = 1,
    parameter int STARVE_LIM     = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic [4:0]  i_core_rs1,
    input  logic [4:0]  i_core_rs2,
    input  logic [4:0]  i_core_rd,
    input  logic        i_core_write,
    input  logic [31:0] i_core_data,
    output logic        o_core_stall,

    input  logic        i_dbg_req,
    input  logic        i_dbg_we,
    input  logic [4:0]  i_dbg_addr,
    input  logic [31:0] i_dbg_wdata,
    output logic        o_dbg_ack,
    output logic [31:0] o_dbg_rdata,

    output logic [4:0]  o_rf_rs1,
    output logic [4:0]  o_rf_rs2,
    output logic [4:0]  o_rf_rd,
    output logic        o_rf_write,
    output logic [31:0] o_rf_data,
    input  logic [31:0] i_rf_data1,

    output logic        o_ready
);

    localparam int StarveW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIM);
    localparam regs_ctrl_state_t ResetState = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
    localparam logic ResetReady = (CLEAR_ON_RESET == 0);

    regs_ctrl_state_t    state_q, state_d;
    logic [4:0]          clrCnt_q, clrCnt_d;
    logic [StarveW-1:0]  starveCnt_q, starveCnt_d;
    logic                ready_q, ready_d;
    logic [31:0]         dbgRdata_q, dbgRdata_d;

    // Next-state logic and register-file port steering; the core is the default owner of every port.
    always_comb begin
        state_d      = state_q;
        clrCnt_d     = clrCnt_q;
        starveCnt_d  = starveCnt_q;
        ready_d      = ready_q;
        dbgRdata_d   = dbgRdata_q;

        o_rf_rs1     = i_core_rs1;
        o_rf_rs2     = i_core_rs2;
        o_rf_rd      = i_core_rd;
        o_rf_data    = i_core_data;
        o_rf_write   = i_core_write && (i_core_rd != REG_ZERO);
        o_core_stall = 1'b0;

        case (state_q)
            CLEAR: begin
                o_rf_write   = 1'b1;
                o_rf_rd      = clrCnt_q;
                o_rf_data    = '0;
                o_core_stall = 1'b1;
                clrCnt_d     = clrCnt_q + 5'd1;
                if (clrCnt_q == REG_LAST) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            IDLE: begin
                if (i_dbg_req && !i_dbg_we) begin
                    // The core is stalled in this cycle, so its write is
                    // held back too; it will be replayed with the rs1 lookup.
                    o_rf_rs1     = i_dbg_addr;
                    o_rf_write   = 1'b0;
                    o_core_stall = 1'b1;
                    state_d      = DBG_RD;
                end else if (i_dbg_req && i_dbg_we) begin
                    if (!i_core_write || (starveCnt_q >= StarveMax)) begin
                        o_rf_rd      = i_dbg_addr;
                        o_rf_data    = i_dbg_wdata;
                        o_rf_write   = (i_dbg_addr != REG_ZERO);
                        o_core_stall = i_core_write;
                        starveCnt_d  = '0;
                        state_d      = DBG_WR;
                    end else if (starveCnt_q != StarveMax) begin
                        starveCnt_d = starveCnt_q + StarveW'(1);
                    end
                end
            end
            DBG_RD: begin
                dbgRdata_d = i_rf_data1;
                state_d    = IDLE;
            end
            DBG_WR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = ResetState;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ResetState;
            clrCnt_q    <= 5'd1;
            starveCnt_q <= '0;
            ready_q     <= ResetReady;
            dbgRdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            clrCnt_q    <= clrCnt_d;
            starveCnt_q <= starveCnt_d;
            ready_q     <= ready_d;
            dbgRdata_q  <= dbgRdata_d;
        end
    end

    // The ack cycle is the state after acceptance; reset in that cycle cancels
    // it, and read data is forwarded straight from the register file so it is
    // valid together with ack.
    assign o_dbg_ack   = ((state_q == DBG_RD) || (state_q == DBG_WR)) && !i_reset;
    assign o_dbg_rdata = ((state_q == DBG_RD) && !i_reset) ? i_rf_data1 : dbgRdata_q;
    assign o_ready     = ready_q;

endmodule
